uart_cmd_framer: RTL and testbench

- Sits between the UART byte receiver and the SPI master / image buffer command consumers on the clk40M domain.
- Assembles received bytes into a fixed 7-byte command frame: sync, cmd, addrLsb, addrMsb, dataLsb, dataMsb, checksum.
- Validates each frame, then presents the command fields with a one-cycle cmdUpdate strobe.
- Discards malformed or stalled frames and flags them.

---
 rtl/uart_cmd_pkg.sv | 21 ++
 rtl/uart_cmd_timeout.sv | 28 ++
 rtl/uart_cmd_framer.sv | 122 ++++++++++++
 tb/tb_uart_cmd_framer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command framer and its helpers.
// Frame layout: sync, cmd, addrLsb, addrMsb, dataLsb, dataMsb, checksum.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_e;

  localparam int FRAME_PAYLOAD_LEN = 5;

  localparam logic [2:0] IDX_CMD  = 3'd0;
  localparam logic [2:0] IDX_ALSB = 3'd1;
  localparam logic [2:0] IDX_AMSB = 3'd2;
  localparam logic [2:0] IDX_DLSB = 3'd3;
  localparam logic [2:0] IDX_DMSB = 3'd4;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Loadable down-counter for inter-byte timeouts: i_load reloads LOAD_VAL,
// i_en counts down, o_expire flags an enabled cycle with the count at zero.
module uart_cmd_timeout #(
  parameter int LOAD_VAL = 399999,
  parameter int W        = $clog2(LOAD_VAL + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(LOAD_VAL);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/uart_cmd_framer.sv
// Assembles 7-byte UART command frames, validates the XOR checksum and
// publishes the command fields with a one-cycle cmdUpdate strobe.
module uart_cmd_framer
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYC = 400000,
  parameter int         CNT_W       = 16
) (
  input  logic             clk40M,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_err,
  output logic             cmdUpdate,
  output logic [7:0]       cmd,
  output logic [7:0]       addrLsb,
  output logic [7:0]       addrMsb,
  output logic [7:0]       dataLsb,
  output logic [7:0]       dataMsb,
  output logic             frameErr,
  output logic             timeoutErr,
  output logic [CNT_W-1:0] frameCnt
);

  state_e     r_state;
  logic [2:0] r_idx;
  logic [7:0] r_chk;
  logic [7:0] r_shadow [FRAME_PAYLOAD_LEN];

  logic w_in_frame;
  logic w_tmo_load;
  logic w_tmo_en;
  logic w_tmo_expire;

  // The counter sits reloaded while hunting, so every frame starts a fresh window.
  assign w_in_frame = (r_state != HUNT);
  assign w_tmo_load = !w_in_frame || rx_valid;
  assign w_tmo_en   = w_in_frame && !rx_valid;

  uart_cmd_timeout #(
    .LOAD_VAL (TIMEOUT_CYC - 1)
  ) u_timeout (
    .clk      (clk40M),
    .rst      (rst),
    .i_load   (w_tmo_load),
    .i_en     (w_tmo_en),
    .o_expire (w_tmo_expire)
  );

  always_ff @(posedge clk40M or posedge rst) begin
    if (rst) begin
      r_state    <= HUNT;
      r_idx      <= '0;
      r_chk      <= '0;
      for (int i = 0; i < FRAME_PAYLOAD_LEN; i++) r_shadow[i] <= '0;
      cmdUpdate  <= 1'b0;
      frameErr   <= 1'b0;
      timeoutErr <= 1'b0;
      cmd        <= '0;
      addrLsb    <= '0;
      addrMsb    <= '0;
      dataLsb    <= '0;
      dataMsb    <= '0;
      frameCnt   <= '0;
    end else begin
      cmdUpdate  <= 1'b0;
      frameErr   <= 1'b0;
      timeoutErr <= 1'b0;
      case (r_state)
        HUNT: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            r_state <= PAYLOAD;
            r_idx   <= '0;
            r_chk   <= '0;
          end
        end
        PAYLOAD: begin
          // rx_err outranks a coincident byte, which outranks an expiring timer.
          if (rx_err) begin
            frameErr <= 1'b1;
            r_state  <= HUNT;
          end else if (rx_valid) begin
            for (int i = 0; i < FRAME_PAYLOAD_LEN; i++) begin
              if (r_idx == 3'(i)) r_shadow[i] <= rx_data;
            end
            r_chk <= r_chk ^ rx_data;
            r_idx <= r_idx + 3'd1;
            if (r_idx == IDX_DMSB) r_state <= CHECK;
          end else if (w_tmo_expire) begin
            timeoutErr <= 1'b1;
            r_state    <= HUNT;
          end
        end
        CHECK: begin
          if (rx_err) begin
            frameErr <= 1'b1;
            r_state  <= HUNT;
          end else if (rx_valid) begin
            if (rx_data == r_chk) begin
              cmd       <= r_shadow[IDX_CMD];
              addrLsb   <= r_shadow[IDX_ALSB];
              addrMsb   <= r_shadow[IDX_AMSB];
              dataLsb   <= r_shadow[IDX_DLSB];
              dataMsb   <= r_shadow[IDX_DMSB];
              cmdUpdate <= 1'b1;
              frameCnt  <= frameCnt + 1'b1;
            end else begin
              frameErr <= 1'b1;
            end
            r_state <= HUNT;
          end else if (w_tmo_expire) begin
            timeoutErr <= 1'b1;
            r_state    <= HUNT;
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed plus randomized bench for uart_cmd_framer against a frame-level model.
module tb_uart_cmd_framer;

  localparam int T  = 16;
  localparam int CW = 2;

  logic          clk40M = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_err;
  logic          cmdUpdate;
  logic [7:0]    cmd, addrLsb, addrMsb, dataLsb, dataMsb;
  logic          frameErr;
  logic          timeoutErr;
  logic [CW-1:0] frameCnt;

  uart_cmd_framer #(
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (T),
    .CNT_W       (CW)
  ) dut (
    .clk40M     (clk40M),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_err     (rx_err),
    .cmdUpdate  (cmdUpdate),
    .cmd        (cmd),
    .addrLsb    (addrLsb),
    .addrMsb    (addrMsb),
    .dataLsb    (dataLsb),
    .dataMsb    (dataMsb),
    .frameErr   (frameErr),
    .timeoutErr (timeoutErr),
    .frameCnt   (frameCnt)
  );

  always #5 clk40M = ~clk40M;

  int checks = 0;
  int errors = 0;

  // strobe monitor: counts every pulse so spurious ones are caught at the end
  int cyc = 0;
  int n_upd = 0, n_ferr = 0, n_terr = 0;
  int last_upd = 0, prev_upd = 0;
  always @(negedge clk40M) begin
    cyc++;
    if (cmdUpdate) begin
      n_upd++;
      prev_upd = last_upd;
      last_upd = cyc;
    end
    if (frameErr)   n_ferr++;
    if (timeoutErr) n_terr++;
  end

  // frame-level reference model
  logic [39:0] m_fields = '0;
  int m_good = 0;
  int m_upd = 0, m_ferr = 0, m_terr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk40M);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic check_fields(input string tag);
    chk({tag, "_fields"}, {24'h0, dataMsb, dataLsb, addrMsb, addrLsb, cmd}, {24'h0, m_fields});
    chk({tag, "_cnt"}, 64'(frameCnt), 64'(m_good % (1 << CW)));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_strobes"}, {61'h0, cmdUpdate, frameErr, timeoutErr}, 64'h0);
    chk({tag, "_fields"}, {24'h0, dataMsb, dataLsb, addrMsb, addrLsb, cmd}, 64'h0);
    chk({tag, "_cnt"}, 64'(frameCnt), 64'h0);
  endtask

  function automatic logic [7:0] xsum(input logic [39:0] pl);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 5; i++) x = x ^ pl[8*i +: 8];
    return x;
  endfunction

  // pl byte 0 is cmd; gap = idle cycles inserted before each byte after sync
  task automatic send_frame(input string tag, input logic [39:0] pl,
                            input logic [7:0] cks, input int gap);
    logic good;
    send_byte(8'hA5);
    for (int i = 0; i < 5; i++) begin
      idle(gap);
      send_byte(pl[8*i +: 8]);
    end
    idle(gap);
    send_byte(cks);
    good = (xsum(pl) == cks);
    chk({tag, "_upd"},  64'(cmdUpdate),  64'(good));
    chk({tag, "_ferr"}, 64'(frameErr),   64'(!good));
    chk({tag, "_terr"}, 64'(timeoutErr), 64'h0);
    if (good) begin
      m_fields = pl;
      m_good++;
      m_upd++;
    end else begin
      m_ferr++;
    end
    check_fields(tag);
  endtask

  logic [39:0] pl;
  logic [7:0]  cks;
  logic [7:0]  gb;
  int          gap;
  int          upd_before;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    idle(3);
    check_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // spec example frame, then a bad checksum, then a new good frame
    pl = 40'hAB_CD_12_34_01;
    send_frame("good", pl, xsum(pl), 0);
    send_frame("badcks", pl, xsum(pl) ^ 8'h01, 0);
    pl = 40'h55_66_77_88_99;
    send_frame("after_bad", pl, xsum(pl), 1);

    // leading garbage is silently dropped
    upd_before = n_upd;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    chk("garbage_strobes", 64'(n_ferr + n_terr), 64'(m_ferr + m_terr));
    pl = 40'hAB_CD_12_34_01;
    send_frame("garbage_frame", pl, xsum(pl), 0);
    chk("garbage_one_upd", 64'(n_upd - upd_before), 64'd1);

    // inter-byte timeout
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h34);
    idle(T - 1);
    chk("tmo_not_yet", 64'(timeoutErr), 64'h0);
    step();
    chk("tmo_pulse", 64'(timeoutErr), 64'h1);
    m_terr++;
    check_fields("tmo");
    pl = 40'h0F_1E_2D_3C_4B;
    send_frame("after_tmo", pl, xsum(pl), 2);

    // every byte lands exactly on the expiry cycle
    pl = 40'hC3_B2_A1_90_8F;
    send_frame("tmo_boundary", pl, xsum(pl), T - 1);

    // rx_err alone inside a frame
    send_byte(8'hA5); send_byte(8'h01);
    rx_err = 1'b1; step(); rx_err = 1'b0;
    chk("rxerr_ferr", 64'(frameErr), 64'h1);
    m_ferr++;
    // rx_err together with a byte
    send_byte(8'hA5); send_byte(8'h01);
    rx_err = 1'b1; rx_valid = 1'b1; rx_data = 8'h34; step();
    rx_err = 1'b0; rx_valid = 1'b0;
    chk("rxerr_valid_ferr", 64'(frameErr), 64'h1);
    m_ferr++;
    check_fields("rxerr");
    // rx_err while hunting is ignored
    rx_err = 1'b1; step(); rx_err = 1'b0;
    chk("rxerr_hunt", 64'(frameErr), 64'h0);
    pl = 40'h11_22_33_44_A5;
    send_frame("after_rxerr", pl, xsum(pl), 0);

    // asynchronous reset mid-frame
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h34);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    m_fields = '0;
    m_good   = 0;
    step();
    rst = 1'b0;
    step();

    // counter wrap, all frames back-to-back
    for (int k = 0; k < 4; k++) begin
      pl = {$urandom, $urandom};
      send_frame("wrap", pl, xsum(pl), 0);
      if (k > 0) chk("b2b_spacing", 64'(last_upd - prev_upd), 64'd7);
    end

    // randomized frames
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        gb = 8'($urandom);
        if (gb == 8'hA5) gb = 8'h3C;
        send_byte(gb);
      end
      pl[31:0]  = $urandom;
      pl[39:32] = 8'($urandom);
      cks = xsum(pl);
      if ($urandom_range(0, 3) == 0) cks = cks ^ (8'h01 << $urandom_range(0, 7));
      gap = ($urandom_range(0, 7) == 0) ? T - 1 : $urandom_range(0, 2);
      send_frame("rand", pl, cks, gap);
    end

    idle(2);
    chk("total_upd",  64'(n_upd),  64'(m_upd));
    chk("total_ferr", 64'(n_ferr), 64'(m_ferr));
    chk("total_terr", 64'(n_terr), 64'(m_terr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
